// File: rtl/mem_arbiter.sv
// mem_arbiter: sole owner of the byte-serial RAM/IO port. Arbitrates between
// instruction fetch and the load/store buffer and runs each access one byte
// per cycle, returning assembled little-endian data with a one-cycle done pulse.
module mem_arbiter #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] IO_BASE    = 'h30000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  ic_req,
  input  logic [ADDR_WIDTH-1:0] ic_addr,
  output logic [31:0]           ic_data,
  output logic                  ic_done,
  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [1:0]            ls_size,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [31:0]           ls_wdata,
  output logic [31:0]           ls_rdata,
  output logic                  ls_done,
  input  logic                  flush,
  input  logic                  io_buffer_full,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LOAD, S_STORE} state_e;
  typedef enum logic {GRANT_IC, GRANT_LS} grant_e;

  state_e                state_q, state_d;
  grant_e                last_q, last_d;
  logic [2:0]            cnt_q, cnt_d, nbytes_q, nbytes_d, cnt_inc;
  logic [ADDR_WIDTH-1:0] base_q, base_d, mem_a_q, mem_a_d;
  logic [31:0]           wdata_q, wdata_d, acc_q, acc_d, acc_ins;
  logic [31:0]           ic_data_q, ic_data_d, ls_rdata_q, ls_rdata_d;
  logic [7:0]            mem_dout_q, mem_dout_d;
  logic                  mem_wr_q, mem_wr_d, is_io_q, is_io_d;
  logic                  ic_done_q, ic_done_d, ls_done_q, ls_done_d;
  logic                  grant_ic, grant_ls, ls_is_io;
  logic [1:0]            rd_idx;

  assign cnt_inc  = cnt_q + 3'd1;
  // mem_din lags mem_a by one cycle, so the edge seen with count c captures byte c-1.
  assign rd_idx   = cnt_q[1:0] - 2'd1;
  assign ls_is_io = (ls_addr >= IO_BASE);

  assign ic_data  = ic_data_q;
  assign ic_done  = ic_done_q & ~flush;
  assign ls_rdata = ls_rdata_q;
  assign ls_done  = ls_done_q;
  assign mem_dout = mem_dout_q;
  assign mem_a    = mem_a_q;
  assign mem_wr   = mem_wr_q & rdy;

  // State and datapath registers; rdy low freezes everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      last_q     <= GRANT_IC;
      cnt_q      <= '0;
      nbytes_q   <= '0;
      base_q     <= '0;
      mem_a_q    <= '0;
      wdata_q    <= '0;
      acc_q      <= '0;
      ic_data_q  <= '0;
      ls_rdata_q <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= 1'b0;
      is_io_q    <= 1'b0;
      ic_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
    end else if (rdy) begin
      state_q    <= state_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      nbytes_q   <= nbytes_d;
      base_q     <= base_d;
      mem_a_q    <= mem_a_d;
      wdata_q    <= wdata_d;
      acc_q      <= acc_d;
      ic_data_q  <= ic_data_d;
      ls_rdata_q <= ls_rdata_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      is_io_q    <= is_io_d;
      ic_done_q  <= ic_done_d;
      ls_done_q  <= ls_done_d;
    end
  end

  // Arbitration, per-byte sequencing and data assembly.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    nbytes_d   = nbytes_q;
    base_d     = base_q;
    mem_a_d    = mem_a_q;
    wdata_d    = wdata_q;
    acc_d      = acc_q;
    ic_data_d  = ic_data_q;
    ls_rdata_d = ls_rdata_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = mem_wr_q;
    is_io_d    = is_io_q;
    ic_done_d  = 1'b0;
    ls_done_d  = 1'b0;
    grant_ic   = 1'b0;
    grant_ls   = 1'b0;
    acc_ins    = acc_q;
    acc_ins[8*rd_idx +: 8] = mem_din;

    unique case (state_q)
      S_IDLE: begin
        mem_wr_d = 1'b0;
        if (!ic_done_q && !ls_done_q) begin
          grant_ic = ic_req && !flush && (!ls_req || last_q == GRANT_LS);
          grant_ls = ls_req && !grant_ic;
        end
        if (grant_ic) begin
          state_d  = S_FETCH;
          last_d   = GRANT_IC;
          base_d   = ic_addr;
          mem_a_d  = ic_addr;
          cnt_d    = '0;
          nbytes_d = 3'd4;
          acc_d    = '0;
        end else if (grant_ls) begin
          last_d   = GRANT_LS;
          base_d   = ls_addr;
          mem_a_d  = ls_addr;
          cnt_d    = '0;
          nbytes_d = (ls_size == 2'd0) ? 3'd1 : (ls_size == 2'd1) ? 3'd2 : 3'd4;
          acc_d    = '0;
          wdata_d  = ls_wdata;
          is_io_d  = ls_is_io;
          if (ls_we) begin
            state_d    = S_STORE;
            mem_dout_d = ls_wdata[7:0];
            mem_wr_d   = !(ls_is_io && io_buffer_full);
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_FETCH, S_LOAD: begin
        if (state_q == S_FETCH && flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_q != 3'd0) acc_d = acc_ins;
          if (cnt_inc < nbytes_q) mem_a_d = base_q + ADDR_WIDTH'(cnt_inc);
          if (cnt_q == nbytes_q) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            if (state_q == S_FETCH) begin
              ic_done_d = 1'b1;
              ic_data_d = acc_ins;
            end else begin
              ls_done_d  = 1'b1;
              ls_rdata_d = acc_ins;
            end
          end
        end
      end
      S_STORE: begin
        // mem_wr_q low means the current byte is still held back by the IO sink.
        if (mem_wr_q) begin
          if (cnt_inc == nbytes_q) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            mem_wr_d  = 1'b0;
            ls_done_d = 1'b1;
          end else begin
            cnt_d      = cnt_inc;
            mem_a_d    = base_q + ADDR_WIDTH'(cnt_inc);
            mem_dout_d = wdata_q[8*cnt_inc[1:0] +: 8];
            mem_wr_d   = !(is_io_q && io_buffer_full);
          end
        end else begin
          mem_wr_d = !(is_io_q && io_buffer_full);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
